// File: rtl/eth_tx_framer.sv
// eth_tx_framer: Ethernet TX framer with preamble/SFD, short-frame
// padding, optional CRC-32 FCS and inter-frame gap enforcement.
module eth_tx_framer #(
  parameter int PREAMB_LEN = 8,
  parameter int IFG_LEN    = 12,
  parameter int MIN_FRAME  = 60,
  parameter bit APPEND_FCS = 1'b1
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] data,
  input  logic       tx_enable,
  output logic       active,
  output logic [7:0] phy_tx_data,
  output logic       phy_tx_valid,
  output logic       tx_error
);
  localparam int CW = (MIN_FRAME > 0) ? $clog2(MIN_FRAME + 1) : 1;
  localparam logic [CW-1:0] MIN_C = CW'(MIN_FRAME);

  typedef logic [PREAMB_LEN-1:0][7:0] sr_t;
  localparam sr_t PRE = {8'hD5, {(PREAMB_LEN-1){8'h55}}};

  typedef enum logic [2:0] {
    IDLE, PAYLOAD, DRAIN, PAD, FCS, GAP
  } state_t;

  state_t state_q, state_d, tail;
  sr_t sr_q;
  logic [PREAMB_LEN-1:0] tag_q;
  logic [31:0] crc_q, fcs;
  logic [CW-1:0] cnt_q, cnt_b;
  logic [7:0] tmr_q, tmr_d;
  logic [7:0] in_byte, out_d, crc_in;
  logic [1:0] fidx;
  logic shift, in_tag, cnt_inc, crc_en;
  logic val_d, err_d;
  logic short_f, last_pad, below_b;

  function automatic logic [31:0] crc8(
    input logic [31:0] c,
    input logic [7:0]  d
  );
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  assign cnt_b = (state_q == IDLE) ? '0 : cnt_q;

  if (MIN_FRAME > 0) begin : g_pad
    assign short_f  = cnt_q < MIN_C;
    assign last_pad = cnt_q == (MIN_C - 1'b1);
    assign below_b  = cnt_b < MIN_C;
  end else begin : g_nopad
    assign short_f  = 1'b0;
    assign last_pad = 1'b0;
    assign below_b  = 1'b0;
  end

  assign fcs    = ~crc_q;
  assign fidx   = 2'd3 - tmr_q[1:0];
  assign active = tx_enable | (state_q != IDLE);
  assign err_d  = tx_enable & (state_q != IDLE)
                & (state_q != PAYLOAD);

  always_comb begin
    state_d = state_q;
    shift   = 1'b0;
    in_byte = 8'h00;
    in_tag  = 1'b0;
    cnt_inc = 1'b0;
    val_d   = 1'b0;
    out_d   = 8'h00;
    crc_en  = 1'b0;
    crc_in  = 8'h00;
    tail    = short_f ? PAD : (APPEND_FCS ? FCS : GAP);
    unique case (state_q)
      IDLE: begin
        if (tx_enable) begin
          state_d = PAYLOAD;
          shift   = 1'b1;
          in_byte = data;
          in_tag  = 1'b1;
          cnt_inc = 1'b1;
        end
      end
      PAYLOAD: begin
        shift = 1'b1;
        if (tx_enable) begin
          in_byte = data;
          in_tag  = 1'b1;
          cnt_inc = 1'b1;
        end else begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        shift = 1'b1;
        if (tmr_q == 8'd0) state_d = tail;
      end
      PAD: begin
        val_d   = 1'b1;
        crc_en  = 1'b1;
        cnt_inc = 1'b1;
        if (last_pad) state_d = APPEND_FCS ? FCS : GAP;
      end
      FCS: begin
        val_d = 1'b1;
        out_d = fcs[8*fidx +: 8];
        if (tmr_q == 8'd0) state_d = GAP;
      end
      GAP: begin
        if (tmr_q == 8'd0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // untagged (preamble/drain) bytes still go out but skip the CRC
    if (shift) begin
      val_d  = 1'b1;
      out_d  = sr_q[0];
      crc_en = tag_q[0];
      crc_in = sr_q[0];
    end
  end

  always_comb begin
    tmr_d = (tmr_q != 8'd0) ? tmr_q - 8'd1 : 8'd0;
    if (state_d != state_q) begin
      unique case (state_d)
        DRAIN:   tmr_d = 8'(PREAMB_LEN - 2);
        FCS:     tmr_d = 8'd3;
        GAP:     tmr_d = 8'(IFG_LEN - 1);
        default: tmr_d = 8'd0;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sr_q         <= PRE;
      tag_q        <= '0;
      crc_q        <= '1;
      cnt_q        <= '0;
      tmr_q        <= '0;
      phy_tx_data  <= 8'h00;
      phy_tx_valid <= 1'b0;
      tx_error     <= 1'b0;
    end else begin
      tmr_q        <= tmr_d;
      phy_tx_data  <= out_d;
      phy_tx_valid <= val_d;
      tx_error     <= err_d;
      if (shift) begin
        sr_q  <= {in_byte, sr_q[PREAMB_LEN-1:1]};
        tag_q <= {in_tag, tag_q[PREAMB_LEN-1:1]};
      end else begin
        sr_q  <= PRE;
        tag_q <= '0;
      end
      if (state_q == IDLE) crc_q <= '1;
      else if (crc_en)     crc_q <= crc8(crc_q, crc_in);
      cnt_q <= (cnt_inc && below_b) ? cnt_b + 1'b1 : cnt_b;
    end
  end
endmodule

// File: tb/tb_eth_tx_framer.sv
// tb_eth_tx_framer: three framer configurations checked cycle by
// cycle against a frame-level expectation model.
module tb_eth_tx_framer;
  localparam int MAXC = 16384;
  localparam int G = 12;

  int PL   [3] = '{8, 8, 2};
  int MINF [3] = '{60, 0, 0};
  int FA   [3] = '{1, 1, 0};

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic [7:0] dat [3];
  logic ten [3];
  logic act [3];
  logic [7:0] pd [3];
  logic pv [3];
  logic perr [3];

  eth_tx_framer u0 (
    .clock(clock), .reset_n(reset_n), .data(dat[0]),
    .tx_enable(ten[0]), .active(act[0]), .phy_tx_data(pd[0]),
    .phy_tx_valid(pv[0]), .tx_error(perr[0]));

  eth_tx_framer #(.PREAMB_LEN(8), .IFG_LEN(12), .MIN_FRAME(0),
    .APPEND_FCS(1'b1)) u1 (
    .clock(clock), .reset_n(reset_n), .data(dat[1]),
    .tx_enable(ten[1]), .active(act[1]), .phy_tx_data(pd[1]),
    .phy_tx_valid(pv[1]), .tx_error(perr[1]));

  eth_tx_framer #(.PREAMB_LEN(2), .IFG_LEN(12), .MIN_FRAME(0),
    .APPEND_FCS(1'b0)) u2 (
    .clock(clock), .reset_n(reset_n), .data(dat[2]),
    .tx_enable(ten[2]), .active(act[2]), .phy_tx_data(pd[2]),
    .phy_tx_valid(pv[2]), .tx_error(perr[2]));

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic       ev [3][MAXC];
  logic [7:0] ed [3][MAXC];
  logic       ea [3][MAXC];
  logic       ee [3][MAXC];

  int nvec = 0;
  int nerr = 0;
  int errcnt [3] = '{0, 0, 0};
  bit run = 1'b0;
  bit cap_on = 1'b0;
  int cap_k = 0;
  logic [7:0] capq [$];
  int capc [$];

  logic [7:0] lit1 [21] = '{8'h55, 8'h55, 8'h55, 8'h55, 8'h55,
    8'h55, 8'h55, 8'hD5, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35,
    8'h36, 8'h37, 8'h38, 8'h39, 8'h26, 8'h39, 8'hF4, 8'hCB};

  task automatic chk(input string nm, input int k,
                     input logic [31:0] got, input logic [31:0] want);
    nvec++;
    if (got !== want) begin
      nerr++;
      if (nerr < 40)
        $display("FAIL %s inst%0d cyc%0d got %0h want %0h",
                 nm, k, cyc, got, want);
    end
  endtask

  // MSB-first CRC over bit-reversed bytes, reversed at the end
  function automatic logic [31:0] fcs_of(input logic [7:0] q [$]);
    logic [31:0] c, r;
    logic [7:0] rb;
    c = 32'hFFFFFFFF;
    foreach (q[i]) begin
      for (int j = 0; j < 8; j++) rb[j] = q[i][7-j];
      c = c ^ {rb, 24'h0};
      for (int j = 0; j < 8; j++)
        c = c[31] ? ((c << 1) ^ 32'h04C11DB7) : (c << 1);
    end
    c = ~c;
    for (int j = 0; j < 32; j++) r[j] = c[31-j];
    return r;
  endfunction

  function automatic logic [31:0] cap_crc(input int lo, input int hi);
    logic [7:0] t [$];
    for (int i = lo; i <= hi; i++) t.push_back(capq[i]);
    return fcs_of(t);
  endfunction

  function automatic logic [31:0] cap_word(input int i);
    return {capq[i+3], capq[i+2], capq[i+1], capq[i]};
  endfunction

  task automatic cap_start(input int k);
    cap_k = k;
    capq.delete();
    capc.delete();
    cap_on = 1'b1;
  endtask

  task automatic send(input int k, input logic [7:0] q [$],
                      output int c, output int len);
    logic [7:0] s [$];
    logic [7:0] body [$];
    logic [31:0] f;
    c = cyc;
    body = q;
    while (body.size() < MINF[k]) body.push_back(8'h00);
    for (int i = 0; i < PL[k]; i++)
      s.push_back((i == PL[k] - 1) ? 8'hD5 : 8'h55);
    foreach (body[i]) s.push_back(body[i]);
    if (FA[k] != 0) begin
      f = fcs_of(body);
      for (int i = 0; i < 4; i++) s.push_back(f[8*i +: 8]);
    end
    len = s.size();
    if (c + len + G + 8 >= MAXC) begin
      $display("FAIL cycle_budget inst%0d cyc%0d", k, cyc);
      $fatal(1);
    end
    for (int i = 0; i < len; i++) begin
      ev[k][c+1+i] = 1'b1;
      ed[k][c+1+i] = s[i];
    end
    for (int t = c + 1; t < c + len + G; t++) ea[k][t] = 1'b1;
    foreach (q[i]) begin
      ten[k] = 1'b1;
      dat[k] = q[i];
      @(posedge clock); #1;
    end
    ten[k] = 1'b0;
    dat[k] = 8'h00;
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) begin
      @(posedge clock); #1;
    end
  endtask

  task automatic inject(input int k, input int g, input int n);
    wait_to(g);
    for (int j = 1; j <= n; j++) ee[k][g+j] = 1'b1;
    ten[k] = 1'b1;
    dat[k] = 8'($urandom_range(0, 255));
    repeat (n) begin
      @(posedge clock); #1;
    end
    ten[k] = 1'b0;
    dat[k] = 8'h00;
  endtask

  function automatic void rnd_frame(output logic [7:0] q [$],
                                    input int n);
    q.delete();
    for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(0, 255)));
  endfunction

  always @(negedge clock) begin
    if (run && cyc < MAXC) begin
      for (int k = 0; k < 3; k++) begin
        chk("valid", k, 32'(pv[k]), 32'(ev[k][cyc]));
        if (ev[k][cyc]) chk("data", k, 32'(pd[k]), 32'(ed[k][cyc]));
        chk("active", k, 32'(act[k]), 32'(ea[k][cyc] | ten[k]));
        chk("tx_error", k, 32'(perr[k]), 32'(ee[k][cyc]));
        if (perr[k]) errcnt[k]++;
      end
      if (cap_on && pv[cap_k]) begin
        capq.push_back(pd[cap_k]);
        capc.push_back(cyc);
      end
    end
  end

  initial begin
    #(10 * (MAXC - 100));
    $display("FAIL watchdog cyc%0d", cyc);
    $fatal(1);
  end

  initial begin
    logic [7:0] q [$];
    logic [7:0] q2 [$];
    int c, len, c2, len2, e0, guard, zc;
    for (int k = 0; k < 3; k++) begin
      ten[k] = 1'b0;
      dat[k] = 8'h00;
      for (int t = 0; t < MAXC; t++) begin
        ev[k][t] = 1'b0;
        ed[k][t] = 8'h00;
        ea[k][t] = 1'b0;
        ee[k][t] = 1'b0;
      end
    end
    repeat (2) @(posedge clock);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("rst_valid", k, 32'(pv[k]), 0);
      chk("rst_data", k, 32'(pd[k]), 0);
      chk("rst_err", k, 32'(perr[k]), 0);
      chk("rst_active", k, 32'(act[k]), 0);
    end
    ten[0] = 1'b1;
    #1 chk("rst_active_tx", 0, 32'(act[0]), 1);
    ten[0] = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b1;
    run = 1'b1;
    @(posedge clock); #1;

    // check value pins the model's CRC
    q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    chk("crc_check_value", 0, fcs_of(q), 32'hCBF43926);

    cap_start(1);
    send(1, q, c, len);
    chk("t1_len", 1, len, 21);
    wait_to(c + 32);
    chk("t1_active_hi", 1, 32'(act[1]), 1);
    wait_to(c + 33);
    chk("t1_active_lo", 1, 32'(act[1]), 0);
    cap_on = 1'b0;
    chk("t1_count", 1, capq.size(), 21);
    for (int i = 0; i < 21; i++)
      chk("t1_byte", 1, 32'(capq[i]), 32'(lit1[i]));
    chk("t1_contig", 1, capc[20] - capc[0], 20);

    cap_start(0);
    rnd_frame(q, 14);
    send(0, q, c, len);
    wait_to(c + len + G);
    cap_on = 1'b0;
    chk("t2_count", 0, capq.size(), 72);
    zc = 0;
    for (int i = 22; i < 68; i++) if (capq[i] != 8'h00) zc++;
    chk("t2_pad_zero", 0, zc, 0);
    chk("t2_fcs", 0, cap_word(68), cap_crc(8, 67));

    cap_start(2);
    q = '{8'hA5};
    send(2, q, c, len);
    wait_to(c + len + G);
    cap_on = 1'b0;
    chk("t3_count", 2, capq.size(), 3);
    chk("t3_b0", 2, 32'(capq[0]), 32'h55);
    chk("t3_b1", 2, 32'(capq[1]), 32'hD5);
    chk("t3_b2", 2, 32'(capq[2]), 32'hA5);
    chk("t3_first", 2, capc[0] - c, 1);
    chk("t3_latency", 2, capc[2] - c, 3);

    cap_start(0);
    e0 = errcnt[0];
    rnd_frame(q, 20);
    send(0, q, c, len);
    inject(0, c + len + 2, 3);
    wait_to(c + len + G);
    cap_on = 1'b0;
    chk("t4_err_pulses", 0, errcnt[0] - e0, 3);
    chk("t4_count", 0, capq.size(), 72);

    rnd_frame(q, 14);
    send(0, q, c, len);
    wait_to(c + 70);
    reset_n = 1'b0;
    #1;
    chk("t5_rst_valid", 0, 32'(pv[0]), 0);
    chk("t5_rst_data", 0, 32'(pd[0]), 0);
    for (int t = c + 70; t < c + len + G; t++) begin
      ev[0][t] = 1'b0;
      ea[0][t] = 1'b0;
      ee[0][t] = 1'b0;
    end
    repeat (2) begin
      @(posedge clock); #1;
    end
    reset_n = 1'b1;
    @(posedge clock); #1;
    cap_start(0);
    send(0, q, c, len);
    wait_to(c + len + G);
    cap_on = 1'b0;
    chk("t5_count", 0, capq.size(), 72);
    chk("t5_fcs", 0, cap_word(68), cap_crc(8, 67));

    cap_start(0);
    rnd_frame(q, 64);
    rnd_frame(q2, 64);
    send(0, q, c, len);
    guard = 0;
    while (act[0] && guard < 300) begin
      @(posedge clock); #1;
      guard++;
    end
    chk("t6_active_drop", 0, 32'(act[0]), 0);
    send(0, q2, c2, len2);
    wait_to(c2 + len2 + G);
    cap_on = 1'b0;
    chk("t6_count", 0, capq.size(), 152);
    chk("t6_gap", 0, capc[76] - capc[75] - 1, G);
    chk("t6_fcs1", 0, cap_word(72), cap_crc(8, 71));
    chk("t6_fcs2", 0, cap_word(148), cap_crc(84, 147));

    for (int it = 0; it < 30; it++) begin
      int k, r, nn;
      k = $urandom_range(0, 2);
      rnd_frame(q, $urandom_range(1, 70));
      send(k, q, c, len);
      if ($urandom_range(0, 1) == 1) begin
        r = $urandom_range(1, 7);
        nn = $urandom_range(1, 3);
        inject(k, c + len + 1 + r, nn);
      end
      wait_to(c + len + G);
      repeat ($urandom_range(0, 3)) begin
        @(posedge clock); #1;
      end
    end

    repeat (2) @(posedge clock);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/eth_tx_framer.md
# eth_tx_framer

Parametrised Ethernet transmit framer between the MAC-side byte stream and the PHY byte interface. It prefixes a configurable preamble/SFD and zero-pads short frames to a minimum length. It optionally computes and appends the IEEE 802.3 CRC-32 FCS, then enforces a configurable inter-frame gap. It supersedes the fixed preamble-only sender. Padding, FCS, protocol-error reporting, reset and registered outputs are new.

## Interface
- PREAMB_LEN, 8: preamble+SFD bytes, range 2..8; bytes 0..L-2 = 0x55, byte L-1 = 0xD5.
- IFG_LEN, 12: idle cycles after the last valid byte, range 1..255.
- MIN_FRAME, 60: minimum payload+pad bytes before the FCS, range 0..1500.
- APPEND_FCS, 1: 1 = append the 4-byte FCS; 0 = no FCS.
- clock  in  1  byte clock; all logic on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- data  in  8  payload byte, sampled while tx_enable = 1.
- tx_enable  in  1  high for N contiguous cycles = one frame of N ≥ 1 bytes.
- active  out  1  combinational: tx_enable | (state != IDLE). Upstream must not start a frame while it is 1.
- phy_tx_data  out  8  registered PHY byte.
- phy_tx_valid  out  1  registered PHY byte strobe.
- tx_error  out  1  registered one-cycle pulse: tx_enable was high outside IDLE/PAYLOAD.

## Operation
- State machine: IDLE, PAYLOAD, DRAIN, PAD, FCS, GAP.
- IDLE
  - Shift register (PREAMB_LEN bytes) holds the preamble pattern; all tag bits = 0.
  - tx_enable = 1 → PAYLOAD.
- PAYLOAD
  - Each cycle: shift data in, tag = 1; register the top byte to the output.
  - tx_enable = 0 → DRAIN.
- DRAIN
  - Shift zeros in, tag = 0, for PREAMB_LEN cycles until the last payload byte has left.
  - Then: PAD if count < MIN_FRAME; else FCS if APPEND_FCS; else GAP.
- CRC
  - Reflected poly 0x04C11DB7, init 0xFFFFFFFF.
  - Updated on every output byte whose tag = 1, and on every pad byte. Never updated on preamble bytes.
- count: saturating payload+pad byte counter, width clog2(MIN_FRAME+1); cleared in IDLE.
- PAD: output 0x00 until count = MIN_FRAME, then → FCS or GAP.
- FCS: output ~crc over 4 cycles, bits [7:0] first, then [15:8], [23:16], [31:24]; then → GAP.
- GAP: phy_tx_valid = 0 for IFG_LEN cycles, then → IDLE.
- Protocol error: tx_enable = 1 in DRAIN, PAD, FCS or GAP.
  - The byte is discarded and tx_error pulses on the next cycle.
  - The frame in progress is unaffected; the violation does not restart or extend it.
- Reset (reset_n = 0, any time, including mid-frame): immediate, asynchronous.
  - state = IDLE; shift register = preamble pattern; tags = 0; crc = 0xFFFFFFFF; count = 0.
  - phy_tx_data = 0x00, phy_tx_valid = 0, tx_error = 0.
  - active = tx_enable.

## Timing
- Let L = PREAMB_LEN and let the first tx_enable high be sampled at edge n.
- phy_tx_valid rises at cycle n+1, carrying P0 = 0x55.
- D0 appears at cycle n+1+L; latency is L+1 cycles for every payload byte.
- Valid output is contiguous, with no gaps:
  - L preamble bytes;
  - N payload bytes;
  - pad = max(0, MIN_FRAME−N) zero bytes;
  - 4·APPEND_FCS FCS bytes.
- Valid length: L + N + pad + 4·APPEND_FCS cycles.
- active stays high from cycle n until IFG_LEN cycles after phy_tx_valid falls, then drops as state returns to IDLE.
- Back-to-back: tx_enable may rise in the first cycle that active is 0, and is accepted there.
- N < L: the drain still takes exactly L cycles; tags keep the preamble out of the CRC.

## Test plan
- MIN_FRAME=0, defaults otherwise; send "123456789" (0x31..0x39) → valid for 21 cycles: 55×7, D5, 31..39, then 26 39 F4 CB; active falls 12 cycles after valid.
- Defaults; 14-byte frame → 8 preamble, 14 data, 46×0x00, 4 FCS = 72 valid cycles; FCS matches a software CRC over the 60 bytes.
- PREAMB_LEN=2, MIN_FRAME=0, APPEND_FCS=0; 1-byte frame 0xA5 → 55, D5, A5 on consecutive cycles, then 12 idle cycles; latency 3 cycles.
- Raise tx_enable for 3 cycles during GAP → tx_error pulses 3 times; no extra valid bytes; frame timing unchanged.
- Assert reset_n=0 in the second FCS byte → phy_tx_valid=0 and data=0x00 immediately; after release, the next frame is bit-exact, with the CRC not polluted.
- Two 64-byte frames, the second started when active first reads 0 → exactly IFG_LEN idle cycles between valid bursts; both FCS values correct.
